// File: rtl/frv_dmem_responder.sv
// Data memory responder for the frv core: fixed-latency stall, range and
// strobe checking, byte-lane writes and a saturating error counter.
module frv_dmem_responder #(
    parameter logic [31:0] MEM_BASE    = 32'h0001_0000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        dmem_cen,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_stall,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,
    output logic [7:0]  err_count
);

    localparam int          AW      = $clog2(MEM_WORDS);
    localparam logic [3:0]  WAIT_N  = 4'(WAIT_CYCLES);
    localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + 33'(4 * MEM_WORDS);
    localparam logic [AW-1:0] BASE_W = MEM_BASE[AW+1:2];

    logic [3:0]    wcnt_q, wcnt_d;
    logic [7:0]    err_q, err_d;
    logic          done;
    logic          rng_err;
    logic          strb_ok;
    logic          strb_err;
    logic          req_err;
    logic          wr_en;
    logic [AW-1:0] idx;
    logic [31:0]   mem_q [MEM_WORDS];

    assign dmem_stall = dmem_cen && (wcnt_q != WAIT_N);
    assign done       = dmem_cen && !dmem_stall;

    // 33-bit upper bound so a window ending at 4 GiB cannot wrap
    assign rng_err = (dmem_addr < MEM_BASE) ||
                     ({1'b0, dmem_addr} >= MEM_END);

    always_comb begin
        strb_ok = 1'b0;
        case ({dmem_addr[1:0], dmem_strb})
            6'b00_1111,
            6'b00_0011,
            6'b10_1100,
            6'b00_0001,
            6'b01_0010,
            6'b10_0100,
            6'b11_1000: strb_ok = 1'b1;
            default:    strb_ok = 1'b0;
        endcase
    end

    assign strb_err   = dmem_wen && !strb_ok;
    assign req_err    = rng_err || strb_err;
    assign dmem_error = done && req_err;
    assign idx        = dmem_addr[AW+1:2] - BASE_W;

    assign dmem_rdata = (done && !dmem_wen && !req_err) ? mem_q[idx] : '0;

    // a request overlapping reset must never reach the array
    assign wr_en = g_resetn && done && dmem_wen && !req_err;

    always_comb begin
        wcnt_d = 4'd0;
        if (dmem_cen && dmem_stall) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (dmem_error && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wcnt_q <= 4'd0;
            err_q  <= 8'd0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge g_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_strb[b]) begin
                    mem_q[idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_frv_dmem_responder.sv
// Directed bench for frv_dmem_responder: one instance with two wait
// states, one with zero wait states.
module tb_frv_dmem_responder;

    localparam logic [31:0] B = 32'h0001_0000;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;

    logic        cen0 = 1'b0, wen0 = 1'b0;
    logic [3:0]  strb0 = 4'hF;
    logic [31:0] addr0 = B, wdata0 = '0;
    logic        stall0, error0;
    logic [31:0] rdata0;
    logic [7:0]  ec0;

    logic        cen1 = 1'b0, wen1 = 1'b0;
    logic [3:0]  strb1 = 4'hF;
    logic [31:0] addr1 = B, wdata1 = '0;
    logic        stall1, error1;
    logic [31:0] rdata1;
    logic [7:0]  ec1;

    int n_chk = 0;
    int n_fail = 0;
    int exp_ec = 0;

    always #5 g_clk = ~g_clk;

    frv_dmem_responder #(
        .MEM_BASE(B), .MEM_WORDS(1024), .WAIT_CYCLES(2)
    ) u_w2 (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .dmem_cen(cen0), .dmem_wen(wen0), .dmem_strb(strb0),
        .dmem_addr(addr0), .dmem_wdata(wdata0),
        .dmem_stall(stall0), .dmem_error(error0),
        .dmem_rdata(rdata0), .err_count(ec0)
    );

    frv_dmem_responder #(
        .MEM_BASE(B), .MEM_WORDS(1024), .WAIT_CYCLES(0)
    ) u_w0 (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .dmem_cen(cen1), .dmem_wen(wen1), .dmem_strb(strb1),
        .dmem_addr(addr1), .dmem_wdata(wdata1),
        .dmem_stall(stall1), .dmem_error(error1),
        .dmem_rdata(rdata1), .err_count(ec1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one request on the two-wait instance, entered at posedge+1
    task automatic xact(input string tag, input logic we,
                        input logic [3:0] st, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic keep);
        cen0 = 1'b1; wen0 = we; strb0 = st; addr0 = a; wdata0 = wd;
        for (int i = 0; i < 2; i++) begin
            @(negedge g_clk);
            check({tag, ":stall"}, 32'(stall0), 32'd1);
            check({tag, ":err_w"}, 32'(error0), 32'd0);
            @(posedge g_clk); #1;
        end
        @(negedge g_clk);
        check({tag, ":done"}, 32'(stall0), 32'd0);
        check({tag, ":err"}, 32'(error0), 32'(exp_err));
        if (!we) check({tag, ":rdata"}, rdata0, exp_rd);
        @(posedge g_clk); #1;
        if (exp_err && exp_ec < 255) exp_ec++;
        check({tag, ":ecnt"}, 32'(ec0), 32'(exp_ec));
        if (!keep) cen0 = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        #2;
        check("rst_ecnt", 32'(ec0), 32'd0);
        check("rst_idle", 32'(stall0), 32'd0);
        cen0 = 1'b1; cen1 = 1'b1;
        #1;
        check("rst_stall_w2", 32'(stall0), 32'd1);
        check("rst_stall_w0", 32'(stall1), 32'd0);
        check("rst_err_w2", 32'(error0), 32'd0);
        cen0 = 1'b0; cen1 = 1'b0;
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        @(posedge g_clk); #1;

        xact("wr8",  1, 4'hF, B + 8,  32'hDEADBEEF, 0, 0, 0);
        xact("rd8",  0, 4'hF, B + 8,  0, 32'hDEADBEEF, 0, 0);
        xact("wb9",  1, 4'h2, B + 9,  32'h0000_5500, 0, 0, 0);
        xact("rd9",  0, 4'hF, B + 8,  0, 32'hDEAD55EF, 0, 0);
        xact("wh10", 1, 4'hC, B + 10, 32'h1234_0000, 0, 0, 0);
        xact("rd10", 0, 4'hF, B + 8,  0, 32'h123455EF, 0, 0);
        xact("wr0",  1, 4'hF, B,      32'hA5A5A5A5, 0, 0, 0);
        xact("rdlo", 0, 4'hF, B - 4,  0, 0, 1, 0);
        xact("wmis", 1, 4'hF, B + 2,  32'hFFFFFFFF, 0, 1, 0);
        xact("wbad", 1, 4'h6, B,      32'hFFFFFFFF, 0, 1, 0);
        xact("rd0",  0, 4'hF, B,      0, 32'hA5A5A5A5, 0, 0);
        xact("wtop", 1, 4'hF, B + 4092, 32'hCAFEF00D, 0, 0, 0);
        xact("rtop", 0, 4'hF, B + 4092, 0, 32'hCAFEF00D, 0, 0);
        xact("rdhi", 0, 4'hF, B + 4096, 0, 0, 1, 0);

        // abort a write after one cycle
        cen0 = 1'b1; wen0 = 1'b1; strb0 = 4'hF; addr0 = B + 8; wdata0 = '0;
        @(negedge g_clk);
        check("abort_stall", 32'(stall0), 32'd1);
        @(posedge g_clk); #1;
        cen0 = 1'b0;
        @(negedge g_clk);
        check("abort_idle", 32'(stall0), 32'd0);
        check("abort_err", 32'(error0), 32'd0);
        @(posedge g_clk); #1;
        check("abort_ecnt", 32'(ec0), 32'(exp_ec));

        xact("bb1", 0, 4'hF, B + 8, 0, 32'h123455EF, 0, 1);
        xact("bb2", 0, 4'hF, B,     0, 32'hA5A5A5A5, 0, 0);

        // 256 errored reads back to back
        cen0 = 1'b1; wen0 = 1'b0; addr0 = B - 4;
        repeat (256 * 3) @(posedge g_clk);
        #1;
        exp_ec = 255;
        check("sat_ecnt", 32'(ec0), 32'(exp_ec));

        addr0 = B + 8;
        @(posedge g_clk); #1;
        #2 g_resetn = 1'b0;
        #1;
        exp_ec = 0;
        check("rst_mid_ecnt", 32'(ec0), 32'd0);
        check("rst_mid_stall", 32'(stall0), 32'd1);
        g_resetn = 1'b1;
        xact("restart", 0, 4'hF, B + 8, 0, 32'h123455EF, 0, 0);

        // zero-wait instance: alternating write/read at the last word
        for (int i = 0; i < 6; i++) begin
            d = 32'h1111_0000 + 32'(i * 32'h0101);
            cen1 = 1'b1; wen1 = 1'b1; strb1 = 4'hF;
            addr1 = B + 4092; wdata1 = d;
            @(negedge g_clk);
            check("w0_wstall", 32'(stall1), 32'd0);
            check("w0_werr", 32'(error1), 32'd0);
            @(posedge g_clk); #1;
            wen1 = 1'b0;
            @(negedge g_clk);
            check("w0_rstall", 32'(stall1), 32'd0);
            check("w0_rdata", rdata1, d);
            @(posedge g_clk); #1;
        end
        addr1 = B + 4096;
        @(negedge g_clk);
        check("w0_hi_err", 32'(error1), 32'd1);
        check("w0_hi_rdata", rdata1, 32'd0);
        @(posedge g_clk); #1;
        cen1 = 1'b0;
        check("w0_ecnt", 32'(ec1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
